// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared pipeline types and constants (fetch FSM, IF/ID record)
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [0:0] {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_stage_if.sv
// ============================================================================
// instr_fetch_stage_if : control, instruction-RAM and IF/ID bundle of IF stage
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_stage_if #(
  parameter int ADDR_W = 11
) ();
  import pipe_pkg::*;

  logic              stall_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              halt_i;
  logic [31:0]       imem_q_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_oen_o;
  logic [31:0]       pc_next_o;
  logic [31:0]       id_pc_o;
  logic [31:0]       id_instr_o;
  logic              id_valid_o;
  logic              halted_o;
  logic              misalign_o;
  logic [31:0]       fetch_count_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, halt_i, imem_q_i,
    output imem_addr_o, imem_oen_o, pc_next_o, id_pc_o, id_instr_o,
           id_valid_o, halted_o, misalign_o, fetch_count_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, halt_i, imem_q_i,
    input  imem_addr_o, imem_oen_o, pc_next_o, id_pc_o, id_instr_o,
           id_valid_o, halted_o, misalign_o, fetch_count_o
  );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_stage_pc_next_mux.sv
// ============================================================================
// pc_next_mux : priority select of the next PC plus redirect alignment check
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_next_mux
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halted_i,
  input  logic        halt_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o,
  output logic        misalign_o
);

  always_comb begin
    misalign_o = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    // EX is older than ID, so a redirect beats a same-cycle halt
    if (!rst_n)                   pc_next_o = RESET_PC;
    else if (redirect_i)          pc_next_o = redirect_pc_i;
    else if (halted_i || halt_i)  pc_next_o = pc_i;
    else if (stall_i)             pc_next_o = pc_i;
    else                          pc_next_o = pc_i + PC_INCR;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_stage.sv
// ============================================================================
// instr_fetch_stage : PC, fetch FSM and IF/ID register of the 5-stage pipeline
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  instr_fetch_stage_if.master bus
);
  import pipe_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  count_q, count_d;
  if_id_t       if_id_q, if_id_d;
  logic [31:0]  pc_next;
  logic         redirect_misaligned;
  logic         halted;

  pc_next_mux #(
    .RESET_PC (RESET_PC)
  ) u_pc_next_mux (
    .rst_n         (rst_n),
    .redirect_i    (bus.redirect_i),
    .redirect_pc_i (bus.redirect_pc_i),
    .halted_i      (halted),
    .halt_i        (bus.halt_i),
    .stall_i       (bus.stall_i),
    .pc_i          (pc_q),
    .pc_next_o     (pc_next),
    .misalign_o    (redirect_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
      if_id_q    <= '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
      if_id_q    <= if_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == FETCH_RUN &&
        (redirect_misaligned || (bus.halt_i && !bus.redirect_i)))
      state_d = FETCH_HALTED;
  end

  always_comb begin
    halted         = (state_q == FETCH_HALTED);
    bus.imem_oen_o = halted && rst_n;
    bus.halted_o   = halted;
  end

  always_comb begin
    // Low bits only matter on a misaligned redirect, where the PC is forced word-aligned
    pc_d       = {pc_next[31:2], 2'b00};
    misalign_d = misalign_q || (state_q == FETCH_RUN && redirect_misaligned);
    if_id_d    = if_id_q;
    count_d    = count_q;
    if (bus.redirect_i || halted || state_d == FETCH_HALTED) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (!bus.stall_i) begin
      if_id_d = '{pc: pc_q, instr: bus.imem_q_i, valid: 1'b1};
      if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
    end
  end

  assign bus.imem_addr_o   = pc_next[ADDR_W+1:2];
  assign bus.pc_next_o     = pc_next;
  assign bus.id_pc_o       = if_id_q.pc;
  assign bus.id_instr_o    = if_id_q.instr;
  assign bus.id_valid_o    = if_id_q.valid;
  assign bus.misalign_o    = misalign_q;
  assign bus.fetch_count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
// ============================================================================
// tb_instr_fetch_stage : directed bench for instr_fetch_stage with a RAM model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem [0:2047];
  logic [31:0] imem_q = 32'd0;
  int          n_chk = 0;
  int          n_fail = 0;

  instr_fetch_stage_if #(.ADDR_W(11)) bus ();

  instr_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .ADDR_W    (11),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!bus.imem_oen_o) imem_q <= mem[bus.imem_addr_o];
  assign bus.imem_q_i = imem_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) mem[k] = 32'h1000_0000 + k;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'd0;
    bus.halt_i = 1'b0;

    repeat (3) step();
    check("rst_valid", {31'd0, bus.id_valid_o}, 32'd0);
    check("rst_id_pc", bus.id_pc_o, 32'h0);
    check("rst_instr", bus.id_instr_o, 32'h0);
    check("rst_count", bus.fetch_count_o, 32'd0);
    check("rst_halted", {31'd0, bus.halted_o}, 32'd0);
    check("rst_oen", {31'd0, bus.imem_oen_o}, 32'd0);
    check("rst_misalign", {31'd0, bus.misalign_o}, 32'd0);

    rst_n = 1'b1;
    step();
    check("run0_pc", bus.id_pc_o, 32'h0);
    check("run0_instr", bus.id_instr_o, 32'h1000_0000);
    check("run0_valid", {31'd0, bus.id_valid_o}, 32'd1);
    step();
    check("run1_pc", bus.id_pc_o, 32'h4);
    check("run1_instr", bus.id_instr_o, 32'h1000_0001);
    step();
    check("run2_pc", bus.id_pc_o, 32'h8);
    check("run2_instr", bus.id_instr_o, 32'h1000_0002);
    check("run2_count", bus.fetch_count_o, 32'd3);

    bus.stall_i = 1'b1;
    #1;
    check("stall_addr", {21'd0, bus.imem_addr_o}, 32'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc", bus.id_pc_o, 32'h8);
      check("stall_instr", bus.id_instr_o, 32'h1000_0002);
      check("stall_addr_hold", {21'd0, bus.imem_addr_o}, 32'd3);
    end
    bus.stall_i = 1'b0;
    step();
    check("resume_pc", bus.id_pc_o, 32'hC);
    check("resume_instr", bus.id_instr_o, 32'h1000_0003);
    check("resume_count", bus.fetch_count_o, 32'd4);
    step();
    check("resume2_pc", bus.id_pc_o, 32'h10);
    check("resume2_count", bus.fetch_count_o, 32'd5);

    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h40;
    bus.stall_i = 1'b1;
    step();
    check("redir_bubble", {31'd0, bus.id_valid_o}, 32'd0);
    check("redir_nop", bus.id_instr_o, 32'h0);
    bus.redirect_i = 1'b0;
    bus.stall_i = 1'b0;
    step();
    check("redir_pc", bus.id_pc_o, 32'h40);
    check("redir_instr", bus.id_instr_o, 32'h1000_0010);
    check("redir_valid", {31'd0, bus.id_valid_o}, 32'd1);
    check("redir_count", bus.fetch_count_o, 32'd6);
    step();
    check("redir_next_pc", bus.id_pc_o, 32'h44);
    check("redir_next_instr", bus.id_instr_o, 32'h1000_0011);

    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h1FFC;
    #1;
    check("wrap_addr_hi", {21'd0, bus.imem_addr_o}, 32'h7FF);
    step();
    check("wrap_bubble", {31'd0, bus.id_valid_o}, 32'd0);
    bus.redirect_i = 1'b0;
    #1;
    check("wrap_addr_lo", {21'd0, bus.imem_addr_o}, 32'h000);
    step();
    check("wrap_pc0", bus.id_pc_o, 32'h1FFC);
    check("wrap_instr0", bus.id_instr_o, 32'h1000_07FF);
    step();
    check("wrap_pc1", bus.id_pc_o, 32'h2000);
    check("wrap_instr1", bus.id_instr_o, 32'h1000_0000);
    check("wrap_count", bus.fetch_count_o, 32'd9);

    bus.halt_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h80;
    step();
    check("hr_not_halted", {31'd0, bus.halted_o}, 32'd0);
    check("hr_bubble", {31'd0, bus.id_valid_o}, 32'd0);
    bus.halt_i = 1'b0;
    bus.redirect_i = 1'b0;
    step();
    check("hr_pc", bus.id_pc_o, 32'h80);
    check("hr_instr", bus.id_instr_o, 32'h1000_0020);
    check("hr_count", bus.fetch_count_o, 32'd10);

    bus.halt_i = 1'b1;
    step();
    check("halt_halted", {31'd0, bus.halted_o}, 32'd1);
    check("halt_oen", {31'd0, bus.imem_oen_o}, 32'd1);
    check("halt_valid", {31'd0, bus.id_valid_o}, 32'd0);
    check("halt_count", bus.fetch_count_o, 32'd10);
    bus.halt_i = 1'b0;
    #1;
    check("halt_pc_frozen", bus.pc_next_o, 32'h84);
    step();
    check("halt_stay", {31'd0, bus.halted_o}, 32'd1);
    check("halt_valid2", {31'd0, bus.id_valid_o}, 32'd0);
    check("halt_count2", bus.fetch_count_o, 32'd10);
    check("halt_pc_frozen2", bus.pc_next_o, 32'h84);

    rst_n = 1'b0;
    step();
    check("mrst_halted", {31'd0, bus.halted_o}, 32'd0);
    check("mrst_count", bus.fetch_count_o, 32'd0);
    check("mrst_pc_next", bus.pc_next_o, 32'h0);
    check("mrst_id_pc", bus.id_pc_o, 32'h0);
    rst_n = 1'b1;
    step();
    check("mrst_run_pc", bus.id_pc_o, 32'h0);
    check("mrst_run_instr", bus.id_instr_o, 32'h1000_0000);
    check("mrst_run_count", bus.fetch_count_o, 32'd1);

    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h46;
    step();
    bus.redirect_i = 1'b0;
    #1;
    check("mis_flag", {31'd0, bus.misalign_o}, 32'd1);
    check("mis_halted", {31'd0, bus.halted_o}, 32'd1);
    check("mis_pc", bus.pc_next_o, 32'h44);
    check("mis_valid", {31'd0, bus.id_valid_o}, 32'd0);
    step();
    check("mis_sticky", {31'd0, bus.misalign_o}, 32'd1);

    rst_n = 1'b0;
    step();
    check("mis_rst_flag", {31'd0, bus.misalign_o}, 32'd0);
    check("mis_rst_halted", {31'd0, bus.halted_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
